// File: rtl/bus_requester.sv
// bus_requester: client-side request/grant FSM for one arbiter port.
// Raises req on an accepted start, performs len+1 granted beats, then
// releases req and waits for gnt to drop before taking another job.
// Optional grant-wait abort is enabled by defining BUS_REQUESTER_TIMEOUT_EN.
module bus_requester #(
    parameter int unsigned LEN_BITS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_BITS-1:0] len,
    input  logic                gnt,
    output logic                req,
    output logic                busy,
    output logic                use_en,
    output logic                done,
    output logic                lost_gnt,
    output logic                timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_REL  = 2'd3
    } state_t;

    // Elaboration guard: a zero timeout would abort before any grant could land
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("bus_requester: TIMEOUT_CYCLES must be at least 1");
    end

    state_t              state, state_next;
    logic [LEN_BITS-1:0] cnt, cnt_next;
    logic                done_next;
    logic                lost_next;

`ifdef BUS_REQUESTER_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              timeout_next;
`endif

    // Next-state, beat counter and pulse decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        lost_next  = 1'b0;
`ifdef BUS_REQUESTER_TIMEOUT_EN
        wait_next    = wait_cnt;
        timeout_next = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    cnt_next   = len;
                    state_next = S_REQ;
`ifdef BUS_REQUESTER_TIMEOUT_EN
                    wait_next  = '0;
`endif
                end
            end
            S_REQ: begin
                if (gnt) begin
                    state_next = S_XFER;
`ifdef BUS_REQUESTER_TIMEOUT_EN
                end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = S_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
`endif
                end
            end
            S_XFER: begin
                if (!gnt) begin
                    state_next = S_REL;
                    lost_next  = 1'b1;
                end else if (cnt == '0) begin
                    state_next = S_REL;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - LEN_BITS'(1);
                end
            end
            S_REL: begin
                if (!gnt) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, counter, pulses and state-decoded outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            lost_gnt <= 1'b0;
            req      <= 1'b0;
            busy     <= 1'b0;
            use_en   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            done     <= done_next;
            lost_gnt <= lost_next;
            req      <= (state_next == S_REQ) || (state_next == S_XFER);
            busy     <= (state_next != S_IDLE);
            use_en   <= (state_next == S_XFER);
        end
    end

`ifdef BUS_REQUESTER_TIMEOUT_EN
    // Grant-wait counter and abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= wait_next;
            timeout  <= timeout_next;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_requester.sv
// Table-driven bench for bus_requester plus hand sequences for reset,
// contention between two instances and the optional grant-wait timeout.
module tb_bus_requester;

    localparam int unsigned LB = 4;

    // Output vector order: {req, busy, use_en, done, lost_gnt, timeout}
    localparam logic [5:0] O_IDLE = 6'b000000;
    localparam logic [5:0] O_REQ  = 6'b110000;
    localparam logic [5:0] O_XFER = 6'b111000;
    localparam logic [5:0] O_REL  = 6'b010000;
    localparam logic [5:0] O_DONE = 6'b010100;
    localparam logic [5:0] O_LOST = 6'b010010;
    localparam logic [5:0] O_TMO  = 6'b000001;

    typedef struct {
        logic          start;
        logic [LB-1:0] len;
        logic          gnt;
        logic [5:0]    exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, start, gnt;
    logic [LB-1:0] len;
    logic          req, busy, use_en, done, lost_gnt, timeout;

    logic          rst_b, start_b, gnt_b;
    logic [LB-1:0] len_b;
    logic          req_b, busy_b, use_en_b, done_b, lost_gnt_b, timeout_b;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    wire [5:0] outs   = {req, busy, use_en, done, lost_gnt, timeout};
    wire [5:0] outs_b = {req_b, busy_b, use_en_b, done_b, lost_gnt_b, timeout_b};

    bus_requester #(.LEN_BITS(LB), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .gnt(gnt),
        .req(req), .busy(busy), .use_en(use_en), .done(done),
        .lost_gnt(lost_gnt), .timeout(timeout)
    );

    bus_requester #(.LEN_BITS(LB), .TIMEOUT_CYCLES(15)) dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .len(len_b), .gnt(gnt_b),
        .req(req_b), .busy(busy_b), .use_en(use_en_b), .done(done_b),
        .lost_gnt(lost_gnt_b), .timeout(timeout_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one clock edge, compare just after it
    task automatic step(input logic s, input logic [LB-1:0] l, input logic g,
                        input logic [5:0] exp, input string name);
        start = s;
        len   = l;
        gnt   = g;
        @(posedge clk);
        #1;
        check(name, outs, exp);
    endtask

    function automatic void add(input logic s, input logic [LB-1:0] l,
                                input logic g, input logic [5:0] e);
        vec_t v;
        v.start = s;
        v.len   = l;
        v.gnt   = g;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    initial begin
        // Single burst len=3, start in XFER and in REL ignored
        add(1, 4'd3, 0, O_REQ);
        add(0, 4'd0, 0, O_REQ);
        add(0, 4'd0, 1, O_XFER);
        add(0, 4'd0, 1, O_XFER);
        add(1, 4'd0, 1, O_XFER);
        add(0, 4'd0, 1, O_XFER);
        add(0, 4'd0, 1, O_DONE);
        add(1, 4'd5, 1, O_REL);
        add(0, 4'd0, 0, O_IDLE);
        // len=0: one beat
        add(1, 4'd0, 0, O_REQ);
        add(0, 4'd0, 1, O_XFER);
        add(0, 4'd0, 1, O_DONE);
        add(0, 4'd0, 0, O_IDLE);
        // len=15: sixteen beats, no wrap
        add(1, 4'd15, 0, O_REQ);
        add(0, 4'd0, 1, O_XFER);
        for (int i = 0; i < 15; i++) add(0, 4'd0, 1, O_XFER);
        add(0, 4'd0, 1, O_DONE);
        add(0, 4'd0, 0, O_IDLE);
        // Lost grant on second beat
        add(1, 4'd3, 0, O_REQ);
        add(0, 4'd0, 1, O_XFER);
        add(0, 4'd0, 0, O_LOST);
        add(0, 4'd0, 0, O_IDLE);
        // Stale grant already high on REQ entry
        add(1, 4'd0, 1, O_REQ);
        add(0, 4'd0, 1, O_XFER);
        add(0, 4'd0, 1, O_DONE);
        add(0, 4'd0, 1, O_REL);
        add(0, 4'd0, 0, O_IDLE);
        add(0, 4'd7, 1, O_IDLE);

        rst_n = 1'b0; start = 1'b0; gnt = 1'b0; len = '0;
        rst_b = 1'b0; start_b = 1'b0; gnt_b = 1'b0; len_b = '0;
        #1;
        check("reset_state", outs, O_IDLE);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rst_b = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].len, vecs[i].gnt, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-XFER clears outputs without a clock edge
        step(1, 4'd3, 0, O_REQ, "mid_rst_req");
        step(0, 4'd0, 1, O_XFER, "mid_rst_xfer");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", outs, O_IDLE);
        gnt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 4'd0, 0, O_REQ, "post_rst_start");
        step(0, 4'd0, 1, O_XFER, "post_rst_xfer");
        step(0, 4'd0, 1, O_DONE, "post_rst_done");
        step(0, 4'd0, 0, O_IDLE, "post_rst_idle");

        // Contention: both wait ungranted, then one is dropped and the other runs
        start_b = 1'b1;
        len_b   = 4'd2;
        step(1, 4'd1, 0, O_REQ, "cont_a_req");
        check("cont_b_req", outs_b, O_REQ);
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 4'd0, 0, O_REQ, "cont_a_wait");
            check("cont_b_wait", outs_b, O_REQ);
        end
        rst_b = 1'b0;
        #1;
        check("cont_b_dropped", outs_b, O_IDLE);
        step(0, 4'd0, 1, O_XFER, "cont_a_xfer1");
        step(0, 4'd0, 1, O_XFER, "cont_a_xfer2");
        step(0, 4'd0, 1, O_DONE, "cont_a_done");
        step(0, 4'd0, 0, O_IDLE, "cont_a_idle");
        rst_b = 1'b1;

`ifdef BUS_REQUESTER_TIMEOUT_EN
        // Fifteen ungranted REQ cycles abort
        step(1, 4'd0, 0, O_REQ, "to_start");
        for (int i = 0; i < 14; i++) step(0, 4'd0, 0, O_REQ, "to_wait");
        step(0, 4'd0, 0, O_TMO, "to_fire");
        step(0, 4'd0, 0, O_IDLE, "to_clear");
        // Grant on the fifteenth cycle wins over the abort
        step(1, 4'd0, 0, O_REQ, "tg_start");
        for (int i = 0; i < 14; i++) step(0, 4'd0, 0, O_REQ, "tg_wait");
        step(0, 4'd0, 1, O_XFER, "tg_grant_wins");
        step(0, 4'd0, 1, O_DONE, "tg_done");
        step(0, 4'd0, 0, O_IDLE, "tg_idle");
`else
        // Without the abort feature REQ waits indefinitely
        step(1, 4'd0, 0, O_REQ, "nt_start");
        for (int i = 0; i < 40; i++) step(0, 4'd0, 0, O_REQ, "nt_wait");
        step(0, 4'd0, 1, O_XFER, "nt_xfer");
        step(0, 4'd0, 1, O_DONE, "nt_done");
        step(0, 4'd0, 0, O_IDLE, "nt_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
